// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Constants shared by the AES_128 core and the stages that consume its
// ciphertext. One AES block is 128 bits and is streamed as 16 bytes.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_BEATS   = AES_BLOCK_W / AES_BYTE_W;

  // Number of output beats needed to carry one block.
  function automatic int beat_count(input int data_w, input int out_w);
    return data_w / out_w;
  endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// -----------------------------------------------------------------------------
// aes_block_fifo
// DEPTH-entry FIFO of whole DATA_W-bit blocks. The head entry is read straight
// out of storage so the serializer can slice beats from registered state.
// Full/empty come from the occupancy count, never from a pointer compare.
//
// Ports
//   clk      in   1         system clock, rising edge
//   reset    in   1         asynchronous, active-high reset
//   i_push   in   1         write i_data at the tail (caller guarantees room)
//   i_pop    in   1         drop the head entry (caller guarantees not empty)
//   i_data   in   DATA_W    block to write
//   o_head   out  DATA_W    oldest stored block
//   o_count  out  CNT_W     number of stored blocks
//   o_full   out  1         o_count == DEPTH
//   o_empty  out  1         o_count == 0
// -----------------------------------------------------------------------------
module aes_block_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // NOTE: storage is deliberately left out of reset; nothing reads an entry
  // before it has been written, because the count gates every read.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so the plain
  // increment wraps modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;  // idle, or push and pop cancel out
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/aes_ct_serializer.sv
// -----------------------------------------------------------------------------
// aes_ct_serializer
// Captures each ciphertext block strobed by AES_128, queues it in a block FIFO
// and emits it MSB first as an OUT_W-bit valid/ready stream. Upstream cannot be
// stalled, so a block arriving with no room is dropped and overflow is latched.
//
// Ports
//   clk         in   1                system clock, rising edge
//   reset       in   1                asynchronous, active-high reset
//   valid_in    in   1                one-cycle strobe: block_in valid
//   block_in    in   DATA_W           ciphertext block
//   out_data    out  OUT_W            current beat (0 while empty)
//   out_valid   out  1                out_data valid
//   out_ready   in   1                sink accepts beat on out_valid & out_ready
//   out_last    out  1                final beat of the current block
//   fifo_count  out  $clog2(DEPTH)+1  whole blocks held, incl. the one in flight
//   overflow    out  1                sticky: a block was dropped
// -----------------------------------------------------------------------------
module aes_ct_serializer
  import aes_pkg::*;
#(
  parameter int DATA_W = AES_BLOCK_W,
  parameter int OUT_W  = AES_BYTE_W,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] block_in,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);

  localparam int BEATS = beat_count(DATA_W, OUT_W);
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  logic [DATA_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_xfer;
  logic              w_final;
  logic              w_accept;
  logic [OUT_W-1:0]  w_beat;

  logic [IDX_W-1:0]  r_beat_idx;
  logic              r_overflow;

  // A beat moves on valid & ready; the final beat also retires the head block.
  assign w_xfer  = out_valid & out_ready;
  assign w_final = w_xfer & (r_beat_idx == LAST_IDX);

  // A full FIFO can still take a block in the cycle its head retires: the
  // freed slot is the one being written, and the count stays put.
  assign w_accept = valid_in & (~w_full | w_final);

  aes_block_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_accept),
    .i_pop   (w_final),
    .i_data  (block_in),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat_idx <= '0;
    end else if (w_xfer) begin
      r_beat_idx <= w_final ? '0 : r_beat_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (valid_in & ~w_accept) begin
      r_overflow <= 1'b1;
    end
  end

  // Beat k is the k-th OUT_W slice counting down from the MSB. Only the head
  // entry and beat index feed this mux, so out_data never sees block_in.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_beat = '0;
    if (!w_empty) begin
      w_beat = w_head[DATA_W-1 - int'(r_beat_idx)*OUT_W -: OUT_W];
    end
  end

  assign out_data   = w_beat;
  assign out_valid  = ~w_empty;
  assign out_last   = out_valid & (r_beat_idx == LAST_IDX);
  assign fifo_count = w_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_aes_ct_serializer.sv
// -----------------------------------------------------------------------------
// tb_aes_ct_serializer
// Directed scenarios plus a randomized phase for aes_ct_serializer. The
// reference model is a queue of whole blocks, a beat counter and a sticky
// drop flag, stepped once per clock from the same inputs the DUT sees.
// -----------------------------------------------------------------------------
module tb_aes_ct_serializer;

  localparam int DATA_W = 128;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 2;
  localparam int BEATS  = DATA_W / OUT_W;
  localparam logic [127:0] REF_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [DATA_W-1:0] block_in;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [1:0]        fifo_count;
  logic              overflow;

  aes_ct_serializer #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .block_in   (block_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [127:0] mq[$];
  int           mk;
  bit           movf;

  // Beats actually transferred by the DUT, and the blocks they should form.
  logic [7:0]   log_d[$];
  bit           log_l[$];
  logic [127:0] exp_blocks[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_beat();
    logic [127:0] h;
    if (mq.size() == 0) return 8'h00;
    h = mq[0];
    return h[127 - 8*mk -: 8];
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+1: compare outputs with the model, apply inputs,
  // clock once, advance the model.
  task automatic step(input bit v, input logic [127:0] b, input bit rdy);
    bit x;
    bit fin;
    bit acc;
    check("out_valid", out_valid, mq.size() != 0);
    check("out_data", out_data, model_beat());
    check("out_last", out_last, (mq.size() != 0) && (mk == BEATS-1));
    check("fifo_count", fifo_count, mq.size());
    check("overflow", overflow, movf);
    valid_in  = v;
    block_in  = b;
    out_ready = rdy;
    if (out_valid && rdy) begin
      log_d.push_back(out_data);
      log_l.push_back(out_last);
    end
    @(posedge clk);
    x   = (mq.size() != 0) && rdy;
    fin = x && (mk == BEATS-1);
    acc = v && ((mq.size() < DEPTH) || fin);
    if (x) begin
      if (fin) begin
        void'(mq.pop_front());
        mk = 0;
      end else begin
        mk++;
      end
    end
    if (acc) mq.push_back(b);
    else if (v) movf = 1'b1;
    #1;
    valid_in = 1'b0;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear
  // before any edge arrives.
  task automatic do_reset();
    #2;
    reset     = 1'b1;
    valid_in  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    mq.delete();
    mk   = 0;
    movf = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Compare the logged transfers with exp_blocks, byte by byte, MSB first.
  task automatic check_stream(input string tag);
    int n;
    logic [127:0] blk;
    n = exp_blocks.size() * BEATS;
    check({tag, "_beats"}, log_d.size(), n);
    for (int j = 0; j < n && j < log_d.size(); j++) begin
      blk = exp_blocks[j / BEATS];
      check({tag, "_byte"}, log_d[j], blk[127 - 8*(j % BEATS) -: 8]);
      check({tag, "_last"}, log_l[j], (j % BEATS) == BEATS-1);
    end
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    exp_blocks.delete();
  endtask

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] c;
    logic [127:0] d;
    logic [127:0] e;

    reset     = 1'b1;
    valid_in  = 1'b0;
    out_ready = 1'b0;
    block_in  = '0;
    mk        = 0;
    movf      = 1'b0;
    #3;
    check("init_out_valid", out_valid, 0);
    check("init_out_data", out_data, 0);
    check("init_out_last", out_last, 0);
    check("init_fifo_count", fifo_count, 0);
    check("init_overflow", overflow, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // T1: single reference block, sink always ready.
    clear_log();
    step(1'b1, REF_CT, 1'b1);
    for (int i = 0; i < BEATS; i++) step(1'b0, '0, 1'b1);
    check("t1_valid_after", out_valid, 0);
    check("t1_count_after", fifo_count, 0);
    exp_blocks.push_back(REF_CT);
    check_stream("t1");

    // T2: ready pattern 1,0,0,1 repeating.
    clear_log();
    a = rand_block();
    step(1'b1, a, 1'b1);
    for (int i = 0; i < 48; i++) step(1'b0, '0, (i % 4 == 0) || (i % 4 == 3));
    exp_blocks.push_back(a);
    check_stream("t2");

    // T6: one block every 16 cycles must give a gapless stream.
    clear_log();
    for (int k = 0; k < 4; k++) begin
      a = rand_block();
      exp_blocks.push_back(a);
      for (int cy = 0; cy < BEATS; cy++) begin
        if (k != 0 || cy != 0) check("t6_continuous", out_valid, 1);
        check("t6_count_le1", fifo_count <= 1, 1);
        check("t6_overflow", overflow, 0);
        step(cy == 0, a, 1'b1);
      end
    end
    for (int i = 0; i < BEATS; i++) step(1'b0, '0, 1'b1);
    check_stream("t6");

    // T3: three pushes into a stalled sink; the third is dropped.
    do_reset();
    a = rand_block();
    b = rand_block();
    c = rand_block();
    step(1'b1, a, 1'b0);
    step(1'b1, b, 1'b0);
    step(1'b1, c, 1'b0);
    check("t3_count", fifo_count, 2);
    check("t3_overflow", overflow, 1);
    clear_log();
    for (int i = 0; i < 2*BEATS + 2; i++) step(1'b0, '0, 1'b1);
    exp_blocks.push_back(a);
    exp_blocks.push_back(b);
    check_stream("t3");
    check("t3_overflow_sticky", overflow, 1);

    // T4: push into a full FIFO on the head's final beat.
    do_reset();
    clear_log();
    a = rand_block();
    b = rand_block();
    d = rand_block();
    step(1'b1, a, 1'b0);
    step(1'b1, b, 1'b0);
    for (int i = 0; i < BEATS-1; i++) step(1'b0, '0, 1'b1);
    check("t4_at_last", out_last, 1);
    step(1'b1, d, 1'b1);
    check("t4_count", fifo_count, 2);
    check("t4_overflow", overflow, 0);
    for (int i = 0; i < 2*BEATS; i++) step(1'b0, '0, 1'b1);
    exp_blocks.push_back(a);
    exp_blocks.push_back(b);
    exp_blocks.push_back(d);
    check_stream("t4");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7) == 0, rand_block(), $urandom_range(0, 9) < 6);
    end

    // T5: reset at beat 7 of A with B queued, then a fresh block E.
    do_reset();
    a = rand_block();
    b = rand_block();
    e = rand_block();
    step(1'b1, a, 1'b0);
    step(1'b1, b, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    check("t5_count_pre", fifo_count, 2);
    do_reset();
    clear_log();
    step(1'b1, e, 1'b1);
    check("t5_e_valid", out_valid, 1);
    check("t5_e_beat0", out_data, e[127:120]);
    for (int i = 0; i < BEATS + 2; i++) step(1'b0, '0, 1'b1);
    exp_blocks.push_back(e);
    check_stream("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
